ulpb_bus_ctrl: RTL

//  Parametrised bus controller for the ULPB ring: detects a start request, gates CLK_EXT onto the ring,
//  and drives the interrupt/echo sequence. Ends each transaction with control-bit cycles and returns
//  the ring to idle. Adds start-glitch rejection, a watchdog forced interrupt, an external interrupt

---
 rtl/ulpb_bus_ctrl.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ulpb_bus_ctrl.sv
// ulpb_bus_ctrl
// Bus master controller for the ULPB ring. Detects a start request on DIN,
// gates CLK_EXT onto the ring, runs the interrupt/echo handshake, issues
// the control-bit cycles and returns the ring to idle. A watchdog limits
// the length of ACTIVE, an external request can force an interrupt, and
// an echo timeout aborts an interrupt that is never acknowledged.
module ulpb_bus_ctrl #(
  parameter int START_CYCLES    = 10,
  parameter int INT_CYCLES      = 6,
  parameter int ECHO_DEPTH      = 3,
  parameter int INT_TIMEOUT     = 64,
  parameter int NUM_CTRL_BITS   = 2,
  parameter int WATCHDOG_CYCLES = 1024
) (
  input  logic CLK_EXT,
  input  logic RESETn,
  input  logic CLKIN,
  output logic CLKOUT,
  input  logic DIN,
  output logic DOUT,
  input  logic EXT_INT_REQ,
  output logic BUS_BUSY,
  output logic TIMEOUT_FLAG,
  input  logic TIMEOUT_CLR
);

  // ------------------------------------------------------------------
  // Counter sizing: each counter holds at most its named maximum value.
  // ------------------------------------------------------------------
  localparam int CNT_W  = (START_CYCLES > 1)    ? $clog2(START_CYCLES)    : 1;
  localparam int ICNT_W = $clog2(INT_TIMEOUT + 1);
  localparam int CCNT_W = (NUM_CTRL_BITS > 1)   ? $clog2(NUM_CTRL_BITS)   : 1;
  localparam int WD_W   = (WATCHDOG_CYCLES > 1) ? $clog2(WATCHDOG_CYCLES) : 1;

  localparam logic [CNT_W-1:0]  START_LOAD = CNT_W'(START_CYCLES - 1);
  localparam logic [ICNT_W-1:0] ICNT_MIN   = ICNT_W'(INT_CYCLES);
  localparam logic [ICNT_W-1:0] ICNT_LAST  = ICNT_W'(INT_TIMEOUT - 1);
  localparam logic [ICNT_W-1:0] ICNT_MAX   = ICNT_W'(INT_TIMEOUT);
  localparam logic [CCNT_W-1:0] CCNT_LOAD  = CCNT_W'(NUM_CTRL_BITS - 1);
  localparam logic [WD_W-1:0]   WD_LAST    = WD_W'((WATCHDOG_CYCLES > 0) ? (WATCHDOG_CYCLES - 1) : 0);
  // A zero watchdog length means the watchdog never fires.
  localparam bit                WD_EN      = (WATCHDOG_CYCLES > 0);

  typedef enum logic [3:0] {
    S_IDLE            = 4'd0,
    S_WAIT_START      = 4'd1,
    S_ARBITRATE       = 4'd2,
    S_PRIO            = 4'd3,
    S_ACTIVE          = 4'd4,
    S_INTERRUPT       = 4'd5,
    S_SWITCH_ROLE     = 4'd6,
    S_LEAVE_INTERRUPT = 4'd7,
    S_CONTROL         = 4'd8,
    S_BACK_TO_IDLE    = 4'd9
  } state_t;

  // ------------------------------------------------------------------
  // State and registers
  // ------------------------------------------------------------------
  state_t                r_state;
  state_t                r_state_neg;
  logic                  r_clk_en;
  logic                  r_bus_busy;
  logic                  r_timeout_flag;
  logic                  r_clkin_neg;
  logic [CNT_W-1:0]      r_cnt;
  logic [ICNT_W-1:0]     r_icnt;
  logic [CCNT_W-1:0]     r_ccnt;
  logic [WD_W-1:0]       r_wd;
  logic [ECHO_DEPTH-1:0] r_echo_neg;
  logic [ECHO_DEPTH-1:0] r_echo_pos;

  logic [ECHO_DEPTH-1:0] w_echo_neg_shift;
  logic [ECHO_DEPTH-1:0] w_echo_pos_shift;
  logic                  w_echo_ok;
  logic                  w_int_req;
  logic                  w_wd_expired;

  // ------------------------------------------------------------------
  // Echo history shift networks: bit 0 takes the newest DIN sample.
  // ------------------------------------------------------------------
  for (genvar gi = 0; gi < ECHO_DEPTH; gi++) begin : g_echo_shift
    if (gi == 0) begin : g_head
      assign w_echo_neg_shift[gi] = DIN;
      assign w_echo_pos_shift[gi] = DIN;
    end else begin : g_tail
      assign w_echo_neg_shift[gi] = r_echo_neg[gi-1];
      assign w_echo_pos_shift[gi] = r_echo_pos[gi-1];
    end
  end

  // The upstream node echoes the interrupt clock inverted: high while
  // CLK_EXT is low (seen at negedge), low while CLK_EXT is high (posedge).
  assign w_echo_ok    = (&r_echo_neg) && !(|r_echo_pos);

  // Interrupt sources that take priority over the watchdog and suppress
  // the timeout flag when they coincide with watchdog expiry.
  assign w_int_req    = !r_clkin_neg || EXT_INT_REQ;
  assign w_wd_expired = WD_EN && (r_wd == WD_LAST);

  // Sample CLKIN, the DIN echo and a copy of the state on the falling edge.
  always_ff @(negedge CLK_EXT or negedge RESETn) begin
    if (!RESETn) begin
      r_clkin_neg <= 1'b1;
      r_state_neg <= S_IDLE;
      r_echo_neg  <= '0;
    end else begin
      r_clkin_neg <= CLKIN;
      r_state_neg <= r_state;
      if (r_state == S_INTERRUPT) begin
        r_echo_neg <= w_echo_neg_shift;
      end else begin
        r_echo_neg <= '0;
      end
    end
  end

  // Rising-edge DIN echo history, only collected while in INTERRUPT.
  always_ff @(posedge CLK_EXT or negedge RESETn) begin
    if (!RESETn) begin
      r_echo_pos <= '0;
    end else if (r_state == S_INTERRUPT) begin
      r_echo_pos <= w_echo_pos_shift;
    end else begin
      r_echo_pos <= '0;
    end
  end

  // Main controller FSM with registered clock enable, busy and timeout flag.
  always_ff @(posedge CLK_EXT or negedge RESETn) begin
    if (!RESETn) begin
      r_state        <= S_IDLE;
      r_clk_en       <= 1'b0;
      r_bus_busy     <= 1'b0;
      r_timeout_flag <= 1'b0;
      r_cnt          <= '0;
      r_icnt         <= '0;
      r_ccnt         <= '0;
      r_wd           <= '0;
    end else begin
      // Clear first so that a set event later in this block wins.
      if (TIMEOUT_CLR) begin
        r_timeout_flag <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (!DIN) begin
            r_state    <= S_WAIT_START;
            r_cnt      <= START_LOAD;
            r_bus_busy <= 1'b1;
          end
        end

        S_WAIT_START: begin
          if (DIN) begin
            // Start pulse too short: treat as a glitch.
            r_state    <= S_IDLE;
            r_bus_busy <= 1'b0;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_state  <= S_ARBITRATE;
            r_clk_en <= 1'b1;
          end
        end

        S_ARBITRATE: begin
          r_state <= S_PRIO;
        end

        S_PRIO: begin
          r_state <= S_ACTIVE;
          r_wd    <= '0;
        end

        S_ACTIVE: begin
          if (w_int_req) begin
            r_state  <= S_INTERRUPT;
            r_clk_en <= 1'b0;
            r_icnt   <= '0;
          end else if (w_wd_expired) begin
            r_state        <= S_INTERRUPT;
            r_clk_en       <= 1'b0;
            r_icnt         <= '0;
            r_timeout_flag <= 1'b1;
          end else if (r_wd != WD_LAST) begin
            r_wd <= r_wd + 1'b1;
          end
        end

        S_INTERRUPT: begin
          if ((r_icnt >= ICNT_MIN) && w_echo_ok) begin
            r_state  <= S_SWITCH_ROLE;
            r_clk_en <= 1'b1;
          end else if (r_icnt == ICNT_LAST) begin
            // No acknowledge from the ring: abort with the clock still off.
            r_state        <= S_BACK_TO_IDLE;
            r_timeout_flag <= 1'b1;
          end else if (r_icnt != ICNT_MAX) begin
            r_icnt <= r_icnt + 1'b1;
          end
        end

        S_SWITCH_ROLE: begin
          r_state <= S_LEAVE_INTERRUPT;
        end

        S_LEAVE_INTERRUPT: begin
          r_state <= S_CONTROL;
          r_ccnt  <= CCNT_LOAD;
        end

        S_CONTROL: begin
          if (r_ccnt == '0) begin
            r_state <= S_BACK_TO_IDLE;
          end else begin
            r_ccnt <= r_ccnt - 1'b1;
          end
        end

        S_BACK_TO_IDLE: begin
          r_state    <= S_IDLE;
          r_clk_en   <= 1'b0;
          r_bus_busy <= 1'b0;
        end

        default: begin
          r_state    <= S_IDLE;
          r_clk_en   <= 1'b0;
          r_bus_busy <= 1'b0;
        end
      endcase
    end
  end

  // Ring data output selected by the falling-edge copy of the state.
  always_comb begin
    DOUT = 1'b1;
    case (r_state_neg)
      S_IDLE, S_WAIT_START, S_ARBITRATE, S_BACK_TO_IDLE: DOUT = 1'b1;
      S_INTERRUPT:                                        DOUT = CLK_EXT;
      default:                                            DOUT = DIN;
    endcase
  end

  // The ring clock idles high whenever the enable is off, including reset.
  assign CLKOUT       = r_clk_en ? CLK_EXT : 1'b1;
  assign BUS_BUSY     = r_bus_busy;
  assign TIMEOUT_FLAG = r_timeout_flag;

endmodule
